// File: rtl/game_button_conditioner.sv
// Push-button front end for the game FSM: sync, debounce, one event per press,
// CEN tick generation and prioritised emission of pending presses on CEN.
//   state        | meaning
//   IDLE         | button released and stable
//   WAIT_PRESS   | raw high, counting towards an accepted press
//   HELD         | press accepted, button still down
//   WAIT_RELEASE | raw low, counting towards an accepted release
module game_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CEN_DIV         = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       BtnC,
    input  logic       BtnL,
    input  logic       BtnR,
    input  logic       BtnD,
    output logic       CEN,
    output logic       Select,
    output logic       selectLeft,
    output logic       selectRight,
    output logic       Quit,
    output logic [3:0] btn_stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int CEN_W = $clog2(CEN_DIV) + 1;
    localparam logic [CEN_W-1:0] CEN_LAST = CEN_W'(CEN_DIV - 1);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] WAIT_PRESS   = 2'd1;
    localparam logic [1:0] HELD         = 2'd2;
    localparam logic [1:0] WAIT_RELEASE = 2'd3;

    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       raw_s;
    logic [3:0]       accept;
    logic [3:0]       pend;
    logic [3:0]       grant;
    logic [CEN_W-1:0] cen_cnt;

    // Bit order {D,R,L,C} is shared by raw, pend, grant and btn_stable.
    assign raw = {BtnD, BtnR, BtnL, BtnC};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            raw_s <= '0;
        end else begin
            sync1 <= raw;
            raw_s <= sync1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic [1:0]       state;
        logic [CNT_W-1:0] cnt;

        // Down-counter loaded with DEBOUNCE_CYCLES-1; terminal count is zero.
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (raw_s[i]) begin
                            state <= WAIT_PRESS;
                            cnt   <= CNT_LOAD;
                        end
                    end
                    WAIT_PRESS: begin
                        if (!raw_s[i])
                            state <= IDLE;
                        else if (cnt == '0)
                            state <= HELD;
                        else
                            cnt <= cnt - 1'b1;
                    end
                    HELD: begin
                        if (!raw_s[i]) begin
                            state <= WAIT_RELEASE;
                            cnt   <= CNT_LOAD;
                        end
                    end
                    WAIT_RELEASE: begin
                        if (raw_s[i])
                            state <= HELD;
                        else if (cnt == '0)
                            state <= IDLE;
                        else
                            cnt <= cnt - 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign accept[i]     = (state == WAIT_PRESS) && raw_s[i] && (cnt == '0);
        assign btn_stable[i] = (state == HELD) || (state == WAIT_RELEASE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            cen_cnt <= '0;
        else if (cen_cnt == CEN_LAST)
            cen_cnt <= '0;
        else
            cen_cnt <= cen_cnt + 1'b1;
    end

    assign CEN = (cen_cnt == CEN_LAST) & ~Reset;

    always_comb begin
        grant = '0;
        if (pend[0])
            grant[0] = 1'b1;
        else if (pend[3])
            grant[3] = 1'b1;
        else if (pend[1])
            grant[1] = 1'b1;
        else if (pend[2])
            grant[2] = 1'b1;
    end

    // A fresh accept on the edge that retires the grant keeps the flag set.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            pend <= '0;
        else
            pend <= (pend & ~(grant & {4{CEN}})) | accept;
    end

    assign Select      = grant[0] & CEN;
    assign selectLeft  = grant[1] & CEN;
    assign selectRight = grant[2] & CEN;
    assign Quit        = grant[3] & CEN;

endmodule

// File: tb/tb_game_button_conditioner.sv
// Bench for game_button_conditioner: two instances (CEN_DIV 4 and 1) against a
// run-length/modulo reference model, plus directed scenarios with literal timing.
module tb_game_button_conditioner;
    localparam int DB = 4;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic BtnC = 1'b0, BtnL = 1'b0, BtnR = 1'b0, BtnD = 1'b0;

    logic       cen_a, sel_a, left_a, right_a, quit_a;
    logic       cen_b, sel_b, left_b, right_b, quit_b;
    logic [3:0] stab_a, stab_b;

    always #5 Clk = ~Clk;

    game_button_conditioner #(.DEBOUNCE_CYCLES(DB), .CEN_DIV(4)) dut_a (
        .Clk(Clk), .Reset(Reset), .BtnC(BtnC), .BtnL(BtnL), .BtnR(BtnR), .BtnD(BtnD),
        .CEN(cen_a), .Select(sel_a), .selectLeft(left_a), .selectRight(right_a),
        .Quit(quit_a), .btn_stable(stab_a));

    game_button_conditioner #(.DEBOUNCE_CYCLES(DB), .CEN_DIV(1)) dut_b (
        .Clk(Clk), .Reset(Reset), .BtnC(BtnC), .BtnL(BtnL), .BtnR(BtnR), .BtnD(BtnD),
        .CEN(cen_b), .Select(sel_b), .selectLeft(left_b), .selectRight(right_b),
        .Quit(quit_b), .btn_stable(stab_b));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [3:0] m_s1 [2];
    bit [3:0] m_s2 [2];
    bit [3:0] m_level [2];
    bit [3:0] m_pend [2];
    int       m_run [2][4];
    int       m_n [2];
    bit       m_cen [2];

    function automatic int div_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int top_pend(input bit [3:0] p);
        if (p[0]) return 0;
        if (p[3]) return 3;
        if (p[1]) return 1;
        if (p[2]) return 2;
        return -1;
    endfunction

    always @(posedge Clk or posedge Reset) begin
        bit [3:0] sample;
        int hp;
        for (int k = 0; k < 2; k++) begin
            if (Reset) begin
                m_s1[k] = '0; m_s2[k] = '0; m_level[k] = '0; m_pend[k] = '0;
                m_n[k] = 0; m_cen[k] = 1'b0;
                for (int b = 0; b < 4; b++) m_run[k][b] = 0;
            end else begin
                hp = top_pend(m_pend[k]);
                if (m_cen[k] && hp >= 0) m_pend[k][hp] = 1'b0;
                sample = m_s2[k];
                m_s2[k] = m_s1[k];
                m_s1[k] = {BtnD, BtnR, BtnL, BtnC};
                // Level flips once DB+1 consecutive synced samples disagree with it.
                for (int b = 0; b < 4; b++) begin
                    if (sample[b] != m_level[k][b]) begin
                        m_run[k][b]++;
                        if (m_run[k][b] == DB + 1) begin
                            m_level[k][b] = sample[b];
                            m_run[k][b] = 0;
                            if (sample[b]) m_pend[k][b] = 1'b1;
                        end
                    end else begin
                        m_run[k][b] = 0;
                    end
                end
                m_n[k]++;
                m_cen[k] = (m_n[k] % div_of(k)) == div_of(k) - 1;
            end
        end
    end

    always @(negedge Clk) begin
        logic [3:0] exp_out;
        int hp;
        for (int k = 0; k < 2; k++) begin
            hp = top_pend(m_pend[k]);
            exp_out = (m_cen[k] && !Reset && hp >= 0) ? (4'b0001 << hp) : 4'b0000;
            if (k == 0) begin
                check("model_cen_a", cen_a, m_cen[k] & ~Reset);
                check("model_out_a", {quit_a, right_a, left_a, sel_a}, exp_out);
                check("model_stable_a", stab_a, m_level[k]);
            end else begin
                check("model_cen_b", cen_b, m_cen[k] & ~Reset);
                check("model_out_b", {quit_b, right_b, left_b, sel_b}, exp_out);
                check("model_stable_b", stab_b, m_level[k]);
            end
        end
    end

    // ---------------- pulse counters ----------------
    int pa [4];
    int pb [4];
    always @(negedge Clk) begin
        logic [3:0] oa, ob;
        oa = {quit_a, right_a, left_a, sel_a};
        ob = {quit_b, right_b, left_b, sel_b};
        for (int b = 0; b < 4; b++) begin
            if (oa[b] === 1'b1) pa[b]++;
            if (ob[b] === 1'b1) pb[b]++;
        end
    end

    task automatic clear_counts();
        for (int b = 0; b < 4; b++) begin
            pa[b] = 0;
            pb[b] = 0;
        end
    endtask

    // ---------------- stimulus ----------------
    int edges = 0;

    task automatic step();
        @(negedge Clk);
        if (!Reset) edges++;
        else edges = 0;
        #2;
    endtask

    task automatic idle(input int n);
        BtnC = 0; BtnL = 0; BtnR = 0; BtnD = 0;
        repeat (n) step();
    endtask

    int  first, ksel, nsel, a, m;
    bit  seen;
    int  hold [4];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with BtnC held: everything quiet, then a Select once released.
        BtnC = 1;
        repeat (5) begin
            step();
            check("rst_outs_a", {cen_a, sel_a, left_a, right_a, quit_a, stab_a}, 0);
            check("rst_outs_b", {cen_b, sel_b, left_b, right_b, quit_b, stab_b}, 0);
        end
        Reset = 0;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sel_a === 1'b1 && first < 0) begin
                first = edges;
                check("rst_sel_cen", cen_a, 1);
            end
        end
        check("rst_sel_edge", first, 7);
        idle(15);

        // Clean press on the CEN_DIV=1 instance.
        clear_counts();
        BtnC = 1;
        ksel = -1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (sel_b === 1'b1) ksel = k;
            check("clean_stable", stab_b[0], (k >= 6) ? 1 : 0);
        end
        check("clean_sel_edge", ksel, 6);
        check("clean_sel_count", pb[0], 1);
        idle(15);

        // Bounce shorter than the debounce window.
        clear_counts();
        seen = 0;
        for (int r = 0; r < 5; r++) begin
            BtnL = 1;
            repeat (3) begin step(); seen |= stab_a[1] | stab_b[1]; end
            BtnL = 0;
            step(); seen |= stab_a[1] | stab_b[1];
        end
        repeat (10) begin step(); seen |= stab_a[1] | stab_b[1]; end
        check("bounce_pulses", pa[1] + pb[1], 0);
        check("bounce_stable", seen, 0);
        idle(5);

        // CEN alignment: accept one cycle after a tick, emit two cycles later.
        for (int i = 0; i < 4 && (edges % 4) != 2; i++) step();
        BtnR = 1;
        a = edges + 7;
        for (int i = 0; i < 14; i++) begin
            step();
            check("align_right_a", right_a, (edges == a + 2) ? 1 : 0);
            check("align_right_b", right_b, (edges == a) ? 1 : 0);
        end
        idle(15);

        // Simultaneous accept of R, D, C.
        BtnR = 1; BtnD = 1; BtnC = 1;
        a = edges + 7;
        m = a;
        while ((m % 4) != 3) m++;
        for (int i = 0; i < 22; i++) begin
            step();
            check("sim_sel", sel_a, (edges == m) ? 1 : 0);
            check("sim_quit", quit_a, (edges == m + 4) ? 1 : 0);
            check("sim_right", right_a, (edges == m + 8) ? 1 : 0);
            check("sim_onehot", ($countones({sel_a, quit_a, left_a, right_a}) <= 1) ? 1 : 0, 1);
        end
        idle(15);

        // Short low glitch while held: no release, no second Quit.
        clear_counts();
        BtnD = 1;
        repeat (10) step();
        BtnD = 0;
        repeat (2) begin step(); check("glitch_stable", stab_a[3], 1); end
        BtnD = 1;
        repeat (15) begin step(); check("glitch_stable", stab_a[3], 1); end
        check("glitch_quit_a", pa[3], 1);
        check("glitch_quit_b", pb[3], 1);
        idle(15);

        // Random stimulus against the model, with occasional resets.
        for (int b = 0; b < 4; b++) hold[b] = 1;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) begin
                hold[b]--;
                if (hold[b] <= 0) begin
                    hold[b] = $urandom_range(1, 10);
                    case (b)
                        0: BtnC = ~BtnC;
                        1: BtnL = ~BtnL;
                        2: BtnR = ~BtnR;
                        default: BtnD = ~BtnD;
                    endcase
                end
            end
            if ($urandom_range(0, 599) == 0) Reset = 1;
            else if (Reset && $urandom_range(0, 1) == 0) Reset = 0;
            step();
        end
        Reset = 0;
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
